// File: rtl/sonar_ping_tx.sv
// ----------------------------------------------------------------------------
// sonar_ping_tx
//
// Sequences a single sonar ping. A ping has two phases:
//   1. A complementary square-wave burst on tx_p/tx_n (BURST).
//   2. An echo-listen window that strobes the receive filter (LISTEN).
// When the ping finishes normally, done pulses for one cycle and the block
// returns to IDLE.
//
// Parameters
//   N            width of half_period, listen_len, samp_div and the cycle
//                counters
//
// Ports
//   clk          single clock; all state changes on its rising edge
//   rst          asynchronous, active-high reset
//   start        one-cycle ping request; only accepted in IDLE
//   abort        ends any ping in progress; wins over start
//   half_period  carrier half-period in clk cycles (0 behaves as 1)
//   n_cycles     number of full carrier cycles in the burst
//   listen_len   length of the listen window in clk cycles
//   samp_div     sample-strobe divider in clk cycles (0 behaves as 1)
//   tx_p, tx_n   complementary transducer drive; both 0 outside BURST
//   busy         high while in BURST or LISTEN
//   sample_en    one-cycle receive strobe on every D-th LISTEN cycle
//   done         one-cycle pulse in the first IDLE cycle after a normal ping
//   state        IDLE=0, BURST=1, LISTEN=2
// ----------------------------------------------------------------------------
module sonar_ping_tx #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         abort,
    input  logic [N-1:0] half_period,
    input  logic [7:0]   n_cycles,
    input  logic [N-1:0] listen_len,
    input  logic [N-1:0] samp_div,
    output logic         tx_p,
    output logic         tx_n,
    output logic         busy,
    output logic         sample_en,
    output logic         done,
    output logic [1:0]   state
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BURST  = 2'd1,
        ST_LISTEN = 2'd2
    } state_t;

    localparam logic [N-1:0] ONE = N'(1);

    state_t       state_q,      state_d;

    // Configuration captured when a ping is accepted. The half-period and
    // sample divider are stored as effective values, with 0 already mapped
    // to 1, so the datapath never has to handle the zero case.
    logic [N-1:0] hp_q,         hp_d;
    logic [7:0]   ncyc_q,       ncyc_d;
    logic [N-1:0] listen_q,     listen_d;
    logic [N-1:0] sdiv_q,       sdiv_d;

    // The burst is counted as (half-level index, cycle within the level).
    // Together these form an (N+9)-bit count. That is enough to reach
    // 2*255*(2^N-1) cycles without wrapping.
    logic [N-1:0] level_cnt_q,  level_cnt_d;
    logic [8:0]   half_idx_q,   half_idx_d;

    // The listen window is counted as (cycle index, phase within divider).
    logic [N-1:0] listen_cnt_q, listen_cnt_d;
    logic [N-1:0] samp_cnt_q,   samp_cnt_d;

    // Registered outputs.
    logic         tx_p_q,       tx_p_d;
    logic         tx_n_q,       tx_n_d;
    logic         busy_q,       busy_d;
    logic         sample_en_q,  sample_en_d;
    logic         done_q,       done_d;

    // Effective values of the live inputs. These are only used in the cycle
    // a start is accepted.
    logic [N-1:0] hp_in_eff;
    logic [N-1:0] sdiv_in_eff;
    logic [8:0]   last_half_idx;

    assign hp_in_eff     = (half_period == '0) ? ONE : half_period;
    assign sdiv_in_eff   = (samp_div == '0) ? ONE : samp_div;
    assign last_half_idx = {ncyc_q, 1'b0} - 9'd1;

    // Next-state and next-output logic.
    //
    // Every output is registered, so each decision here sets the values that
    // will be visible in the next cycle.
    //
    // On entry to LISTEN, the first listen cycle is "cycle 1". Its strobe is
    // therefore only set when the divider is 1.
    always_comb begin
        state_d      = state_q;
        hp_d         = hp_q;
        ncyc_d       = ncyc_q;
        listen_d     = listen_q;
        sdiv_d       = sdiv_q;
        level_cnt_d  = level_cnt_q;
        half_idx_d   = half_idx_q;
        listen_cnt_d = listen_cnt_q;
        samp_cnt_d   = samp_cnt_q;
        tx_p_d       = tx_p_q;
        tx_n_d       = tx_n_q;
        sample_en_d  = 1'b0;
        done_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    hp_d     = hp_in_eff;
                    ncyc_d   = n_cycles;
                    listen_d = listen_len;
                    sdiv_d   = sdiv_in_eff;
                    if (n_cycles != 8'd0) begin
                        state_d     = ST_BURST;
                        tx_p_d      = 1'b1;
                        tx_n_d      = 1'b0;
                        level_cnt_d = ONE;
                        half_idx_d  = 9'd0;
                    end else if (listen_len != '0) begin
                        state_d      = ST_LISTEN;
                        listen_cnt_d = ONE;
                        samp_cnt_d   = ONE;
                        sample_en_d  = (sdiv_in_eff == ONE);
                    end else begin
                        // Empty ping: nothing to transmit or listen for.
                        done_d = 1'b1;
                    end
                end
            end

            ST_BURST: begin
                if (level_cnt_q == hp_q) begin
                    if (half_idx_q == last_half_idx) begin
                        tx_p_d      = 1'b0;
                        tx_n_d      = 1'b0;
                        level_cnt_d = '0;
                        half_idx_d  = 9'd0;
                        if (listen_q != '0) begin
                            state_d      = ST_LISTEN;
                            listen_cnt_d = ONE;
                            samp_cnt_d   = ONE;
                            sample_en_d  = (sdiv_q == ONE);
                        end else begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        tx_p_d      = ~tx_p_q;
                        tx_n_d      = ~tx_n_q;
                        level_cnt_d = ONE;
                        half_idx_d  = half_idx_q + 9'd1;
                    end
                end else begin
                    level_cnt_d = level_cnt_q + ONE;
                end
            end

            ST_LISTEN: begin
                if (listen_cnt_q == listen_q) begin
                    state_d      = ST_IDLE;
                    done_d       = 1'b1;
                    listen_cnt_d = '0;
                    samp_cnt_d   = '0;
                end else begin
                    listen_cnt_d = listen_cnt_q + ONE;
                    if (samp_cnt_q == sdiv_q) begin
                        samp_cnt_d = ONE;
                    end else begin
                        samp_cnt_d = samp_cnt_q + ONE;
                    end
                    sample_en_d = (samp_cnt_d == sdiv_q);
                end
            end

            default: begin
                state_d = ST_IDLE;
                tx_p_d  = 1'b0;
                tx_n_d  = 1'b0;
            end
        endcase

        // Abort overrides everything else, including a start in IDLE.
        // The captured configuration is left in place; it is harmless
        // because the next accepted start overwrites it.
        if (abort) begin
            state_d      = ST_IDLE;
            level_cnt_d  = '0;
            half_idx_d   = 9'd0;
            listen_cnt_d = '0;
            samp_cnt_d   = '0;
            tx_p_d       = 1'b0;
            tx_n_d       = 1'b0;
            sample_en_d  = 1'b0;
            done_d       = 1'b0;
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State, configuration, counter and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            hp_q         <= '0;
            ncyc_q       <= 8'd0;
            listen_q     <= '0;
            sdiv_q       <= '0;
            level_cnt_q  <= '0;
            half_idx_q   <= 9'd0;
            listen_cnt_q <= '0;
            samp_cnt_q   <= '0;
            tx_p_q       <= 1'b0;
            tx_n_q       <= 1'b0;
            busy_q       <= 1'b0;
            sample_en_q  <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            hp_q         <= hp_d;
            ncyc_q       <= ncyc_d;
            listen_q     <= listen_d;
            sdiv_q       <= sdiv_d;
            level_cnt_q  <= level_cnt_d;
            half_idx_q   <= half_idx_d;
            listen_cnt_q <= listen_cnt_d;
            samp_cnt_q   <= samp_cnt_d;
            tx_p_q       <= tx_p_d;
            tx_n_q       <= tx_n_d;
            busy_q       <= busy_d;
            sample_en_q  <= sample_en_d;
            done_q       <= done_d;
        end
    end

    assign tx_p      = tx_p_q;
    assign tx_n      = tx_n_q;
    assign busy      = busy_q;
    assign sample_en = sample_en_q;
    assign done      = done_q;
    assign state     = state_q;

endmodule

// File: tb/tb_sonar_ping_tx.sv
// ----------------------------------------------------------------------------
// tb_sonar_ping_tx
//
// Testbench for sonar_ping_tx.
//
// A closed-form timing model predicts the output vector of every cycle:
//   - it tracks the cycle offset since the accepted start;
//   - each prediction is pushed to a scoreboard queue when stimulus is driven;
//   - it is popped and compared one time unit after the following clock edge.
//
// A table of ping configurations also carries hand-derived totals (done
// offset, sample strobe count, tx_p high cycles), which are checked per ping.
// Hand-written sequences cover:
//   - abort;
//   - ignored starts and mid-ping config changes;
//   - start together with abort;
//   - back-to-back pings;
//   - asynchronous reset.
// ----------------------------------------------------------------------------
module tb_sonar_ping_tx;

    localparam int N = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         abort;
    logic [N-1:0] half_period;
    logic [7:0]   n_cycles;
    logic [N-1:0] listen_len;
    logic [N-1:0] samp_div;
    logic         tx_p;
    logic         tx_n;
    logic         busy;
    logic         sample_en;
    logic         done;
    logic [1:0]   state;

    sonar_ping_tx #(.N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .half_period(half_period),
        .n_cycles   (n_cycles),
        .listen_len (listen_len),
        .samp_div   (samp_div),
        .tx_p       (tx_p),
        .tx_n       (tx_n),
        .busy       (busy),
        .sample_en  (sample_en),
        .done       (done),
        .state      (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        int hp;
        int nc;
        int ll;
        int sd;
        int exp_done;
        int exp_samples;
        int exp_txp;
    } vec_t;

    vec_t vecs[8];

    // Scoreboard: {state[1:0], busy, tx_p, tx_n, sample_en, done}
    logic [6:0] exp_q[$];

    int n_compared   = 0;
    int n_mismatched = 0;

    // Configuration currently driven on the inputs.
    int cfg_hp, cfg_nc, cfg_ll, cfg_sd;

    // Reference model state.
    bit m_active;
    int m_t, m_hp, m_nc, m_ll, m_sd;
    int cyc = 0;

    // Observations collected while a table ping runs.
    int first_done, n_samples, n_txp;

    // Predicted output vector for cycle offset k after an accepted start.
    function automatic logic [6:0] modelOut(input int k);
        int   b;
        logic ph;
        logic s;
        b = 2 * m_nc * m_hp;
        if (k >= 1 && k <= b) begin
            ph = (((k - 1) / m_hp) % 2) == 0;
            return {2'd1, 1'b1, ph, ~ph, 1'b0, 1'b0};
        end else if (k > b && k <= b + m_ll) begin
            s = ((k - b) % m_sd) == 0;
            return {2'd2, 1'b1, 1'b0, 1'b0, s, 1'b0};
        end else if (k == b + m_ll + 1) begin
            return 7'b0000001;
        end
        return 7'b0000000;
    endfunction

    // Drive one cycle of stimulus at the falling edge and push the
    // prediction for the next cycle. Returns #1 after the rising edge.
    task automatic applyStimulus(input logic s, input logic a);
        int         c;
        bit         idle_now;
        logic [6:0] e;
        @(negedge clk);
        start       = s;
        abort       = a;
        half_period = N'(cfg_hp);
        n_cycles    = 8'(cfg_nc);
        listen_len  = N'(cfg_ll);
        samp_div    = N'(cfg_sd);
        c   = cyc;
        cyc = cyc + 1;
        idle_now = !m_active || ((c - m_t) >= 2 * m_nc * m_hp + m_ll + 1);
        if (a) begin
            m_active = 1'b0;
            e = 7'b0;
        end else if (s && idle_now) begin
            m_active = 1'b1;
            m_t  = c;
            m_hp = (cfg_hp == 0) ? 1 : cfg_hp;
            m_nc = cfg_nc;
            m_ll = cfg_ll;
            m_sd = (cfg_sd == 0) ? 1 : cfg_sd;
            e = modelOut(1);
        end else if (m_active) begin
            e = modelOut(c + 1 - m_t);
        end else begin
            e = 7'b0;
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name);
        logic [6:0] e;
        logic [6:0] act;
        act = {state, busy, tx_p, tx_n, sample_en, done};
        n_compared = n_compared + 1;
        if (exp_q.size() == 0) begin
            n_mismatched = n_mismatched + 1;
            $display("[TB] FAIL %s: scoreboard empty, got %b", name, act);
        end else begin
            e = exp_q.pop_front();
            if (act !== e) begin
                n_mismatched = n_mismatched + 1;
                $display("[TB] FAIL %s cycle %0d: got %b expected %b (st,busy,p,n,se,done)",
                         name, cyc, act, e);
            end
        end
    endtask

    task automatic compareInt(input string name, input int act, input int e);
        n_compared = n_compared + 1;
        if (act != e) begin
            n_mismatched = n_mismatched + 1;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, e);
        end
    endtask

    task automatic setCfg(input int hp, input int nc, input int ll, input int sd);
        cfg_hp = hp;
        cfg_nc = nc;
        cfg_ll = ll;
        cfg_sd = sd;
    endtask

    task automatic observe(input int k);
        if (done && first_done < 0) first_done = k;
        if (sample_en) n_samples = n_samples + 1;
        if (tx_p) n_txp = n_txp + 1;
    endtask

    // Run one complete ping and check its per-cycle outputs and totals.
    task automatic runVec(input int idx);
        setCfg(vecs[idx].hp, vecs[idx].nc, vecs[idx].ll, vecs[idx].sd);
        first_done = -1;
        n_samples  = 0;
        n_txp      = 0;
        for (int k = 1; k <= vecs[idx].exp_done + 2; k++) begin
            applyStimulus(k == 1, 1'b0);
            checkOutput($sformatf("vec%0d", idx));
            observe(k);
        end
        compareInt($sformatf("vec%0d done offset", idx), first_done, vecs[idx].exp_done);
        compareInt($sformatf("vec%0d sample count", idx), n_samples, vecs[idx].exp_samples);
        compareInt($sformatf("vec%0d tx_p cycles", idx), n_txp, vecs[idx].exp_txp);
    endtask

    initial begin
        // Fields: hp, n_cycles, listen_len, samp_div,
        //         done offset, sample_en pulses, tx_p cycles
        vecs[0] = '{2,   3, 10, 4, 23,   2,   6};
        vecs[1] = '{7,   0,  5, 0,  6,   5,   0};
        vecs[2] = '{0,   1,  0, 3,  3,   0,   1};
        vecs[3] = '{4,   0,  0, 2,  1,   0,   0};
        vecs[4] = '{3,   2,  7, 3, 20,   2,   6};
        vecs[5] = '{1,   4,  3, 2, 12,   1,   4};
        vecs[6] = '{5,   1,  4, 5, 15,   0,   5};
        vecs[7] = '{300, 2,  3, 2, 1204, 1, 600};

        rst         = 1'b1;
        start       = 1'b0;
        abort       = 1'b0;
        half_period = '0;
        n_cycles    = 8'd0;
        listen_len  = '0;
        samp_div    = '0;
        m_active    = 1'b0;
        m_t = 0; m_hp = 1; m_nc = 0; m_ll = 0; m_sd = 1;
        setCfg(0, 0, 0, 0);

        #2;
        exp_q.push_back(7'b0);
        checkOutput("reset state");
        @(negedge clk);
        rst = 1'b0;

        applyStimulus(1'b0, 1'b0);
        checkOutput("idle after reset");

        for (int i = 0; i < 8; i++) begin
            runVec(i);
        end

        // Abort during the second half-cycle of the burst, then a full ping.
        setCfg(2, 3, 10, 4);
        for (int k = 1; k <= 3; k++) begin
            applyStimulus(k == 1, 1'b0);
            checkOutput("pre-abort");
        end
        applyStimulus(1'b0, 1'b1);
        checkOutput("abort");
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0, 1'b0);
            checkOutput("post-abort idle");
        end
        runVec(0);

        // Start and abort together in IDLE: nothing happens.
        applyStimulus(1'b1, 1'b1);
        checkOutput("start+abort idle");
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 1'b0);
            checkOutput("start+abort after");
        end

        // Starts while busy, config changes mid-ping, then start on done.
        setCfg(2, 3, 10, 4);
        first_done = -1;
        for (int k = 1; k <= 30; k++) begin
            if (k == 5) setCfg(7, 9, 2, 1);
            if (k == 24) setCfg(1, 1, 2, 1);
            applyStimulus(k == 1 || k == 5 || k == 15 || k == 24, 1'b0);
            checkOutput("busy start");
            if (done && first_done < 0) first_done = k;
        end
        compareInt("ignored starts done offset", first_done, 23);

        // Asynchronous reset in the middle of LISTEN.
        setCfg(2, 3, 10, 4);
        for (int k = 1; k <= 15; k++) begin
            applyStimulus(k == 1, 1'b0);
            checkOutput("pre-reset");
        end
        #2;
        rst = 1'b1;
        #1;
        m_active = 1'b0;
        exp_q.push_back(7'b0);
        checkOutput("async reset");
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            applyStimulus(1'b0, 1'b0);
            checkOutput("post-reset idle");
        end
        runVec(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
